memoryaccessing: RTL and testbench
==================================

# memoryAccessing

Memory stage of the MIPS pipeline, directly downstream of `executing`. It holds the EX/MEM pipeline register and resolves branches from the ALU zero flag. It also performs byte/half/word loads and stores on an internal word-addressed data memory with configurable wait states, and drives registered MEM/WB results to the write-back stage. While a memory access is waiting it raises a stall to freeze upstream stages.

## Interface
- `DEPTH`, 256: data memory size in 32-bit words (power of two); index = `resultAluOutput[log2(DEPTH)+1:2]`.
- `WAIT_STATES`, 2: extra cycles a load/store occupies EX/MEM (0..15).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `resultAluOutput` in 32: ALU result / effective address from `executing`.
- `isAluOutputZero` in 1: ALU zero flag from `executing`.
- `addressRegWrite` in 5: destination register from `executing`.
- `writeData` in 32: store data (rt value).
- `branchTarget` in 32: computed branch target.
- `regWrite`, `memRead`, `memWrite`, `memToReg`, `branch`, `memUnsigned` in 1 each: control bits.
- `memSize` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `memStall` out 1: upstream must hold; EX/MEM does not capture.
- `pcSrc` out 1: taken branch = EX/MEM.branch & EX/MEM.zero.
- `pcBranch` out 32: EX/MEM.branchTarget.
- `writeBackData` out 32: load data (memToReg) or ALU result.
- `writeBackAddress` out 5: destination register.
- `writeBackEnable` out 1: register-file write enable.
- `misalignedException` out 1: one-cycle pulse on misaligned access.

## Operation
- EX/MEM register captures all inputs on each rising edge where `memStall`=0; otherwise it holds.
- Memory op means EX/MEM.memRead or EX/MEM.memWrite. If both are set, memRead wins and the store is suppressed.
- FSM states:
  - IDLE. A memory op present with `WAIT_STATES`>0 → WAIT, counter=0. With `WAIT_STATES`=0 the op completes at the next edge and the FSM stays in IDLE.
  - WAIT. Counter increments each edge. When counter reaches `WAIT_STATES`-1 the next edge completes the access → IDLE.
- `memStall` = memory op in EX/MEM and the access is not completing at the next edge (combinational from state/counter/EX/MEM).
- Alignment:
  - half requires addr[0]=0; word requires addr[1:0]=00.
  - Misaligned: no stall, no memory write, `writeBackEnable`=0, `misalignedException`=1 for one cycle at MEM/WB.
- Byte lanes are little-endian: addr[1:0]=0 → bits 7:0.
  - Stores write only the addressed byte/half lanes.
  - Loads sign-extend unless `memUnsigned`.
- MEM/WB registers update at the completing edge:
  - non-memory ops: edge after capture.
  - memory ops: capture edge + `WAIT_STATES`+1.
  - While stalled, MEM/WB receives a bubble: `writeBackEnable`=0, `misalignedException`=0.
- `writeBackEnable` = EX/MEM.regWrite and not misaligned. Register 0 is passed as is; the register file ignores it.
- Memory contents are not reset.

## Timing
- Reset (asynchronous assert) clears EX/MEM, FSM→IDLE, counter=0. All outputs read 0: `memStall`, `pcSrc`, `pcBranch`, `writeBack*`, `misalignedException`.
- Reset mid-access aborts it: a pending store is not written and no load result appears.
- `pcSrc`/`pcBranch` are valid the whole cycle after the capture edge. Upstream flush on `pcSrc` is the hazard unit's job.
- Back-to-back memory ops: the second is captured at the completing edge of the first. No idle cycle is inserted.
- Load followed by an ALU op: the ALU op is held upstream while `memStall`=1 and captured at the load's completing edge.
- Memory address wraps modulo `DEPTH` words; upper address bits are ignored.

## Test plan
- Reset low mid-run → all outputs 0 immediately; after release, an ALU op result 0x1234 to r5 gives `writeBackData`=0x1234, `writeBackAddress`=5, `writeBackEnable`=1 one edge after capture.
- Word store 0xDEADBEEF @0x10, then word load @0x10 (`WAIT_STATES`=2) → `memStall` high 2 cycles per op; load returns 0xDEADBEEF at capture+3 edges.
- Byte store 0x80 @0x13, then signed and unsigned byte loads @0x13 → 0xFFFFFF80 / 0x00000080; other lanes of word 0x10 unchanged.
- Half load @0x11 and word store @0x22 → `misalignedException` pulse, `writeBackEnable`=0, no stall, memory unchanged.
- Branch with zero=1, target 0x400 → `pcSrc`=1, `pcBranch`=0x400 for one cycle; with zero=0 → `pcSrc`=0.
- Store with reset asserted in its WAIT cycle → memory word unchanged on reload; `WAIT_STATES`=0 build: loads/stores complete with no stall.

Source files
------------

// File: rtl/memoryaccessing.sv
// MIPS memory stage: EX/MEM register, branch resolution, wait-stated byte/half/word
// data memory access and registered MEM/WB results for write-back.
module memoryaccessing #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] resultAluOutput,
  input  logic        isAluOutputZero,
  input  logic [4:0]  addressRegWrite,
  input  logic [31:0] writeData,
  input  logic [31:0] branchTarget,
  input  logic        regWrite,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        memToReg,
  input  logic        branch,
  input  logic        memUnsigned,
  input  logic [1:0]  memSize,
  output logic        memStall,
  output logic        pcSrc,
  output logic [31:0] pcBranch,
  output logic [31:0] writeBackData,
  output logic [4:0]  writeBackAddress,
  output logic        writeBackEnable,
  output logic        misalignedException
);
  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam logic [3:0]  LAST_CNT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state;
  logic [3:0]  cnt;

  logic [31:0] ex_alu;
  logic        ex_zero;
  logic [4:0]  ex_rd;
  logic [31:0] ex_wdata;
  logic [31:0] ex_target;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_memtoreg;
  logic        ex_branch;
  logic        ex_uns;
  logic [1:0]  ex_size;

  logic [31:0] mem [DEPTH];

  logic             mem_op;
  logic             misaligned;
  logic             completing;
  logic             do_store;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_word;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [31:0]      load_data;

  assign idx        = ex_alu[IDX_W+1:2];
  assign mem_op     = ex_memread | ex_memwrite;
  assign misaligned = mem_op & (((ex_size == 2'b01) & ex_alu[0]) |
                                (ex_size[1] & (ex_alu[1:0] != 2'b00)));
  // Misaligned accesses never touch memory, so they complete without waiting.
  assign completing = (WAIT_STATES == 0) || ((state == S_WAIT) && (cnt == LAST_CNT));
  assign memStall   = mem_op & ~misaligned & ~completing;
  assign do_store   = ex_memwrite & ~ex_memread & ~misaligned & ~memStall;

  assign pcSrc    = ex_branch & ex_zero;
  assign pcBranch = ex_target;

  always_comb begin
    rd_word = mem[idx];
    lane_b  = rd_word[{ex_alu[1:0], 3'b000} +: 8];
    lane_h  = rd_word[{ex_alu[1], 4'b0000} +: 16];
    unique case (ex_size)
      2'b00:   load_data = ex_uns ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_data = ex_uns ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_data = rd_word;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state               <= S_IDLE;
      cnt                 <= '0;
      ex_alu              <= '0;
      ex_zero             <= 1'b0;
      ex_rd               <= '0;
      ex_wdata            <= '0;
      ex_target           <= '0;
      ex_regwrite         <= 1'b0;
      ex_memread          <= 1'b0;
      ex_memwrite         <= 1'b0;
      ex_memtoreg         <= 1'b0;
      ex_branch           <= 1'b0;
      ex_uns              <= 1'b0;
      ex_size             <= '0;
      writeBackData       <= '0;
      writeBackAddress    <= '0;
      writeBackEnable     <= 1'b0;
      misalignedException <= 1'b0;
    end else begin
      if (!memStall) begin
        ex_alu      <= resultAluOutput;
        ex_zero     <= isAluOutputZero;
        ex_rd       <= addressRegWrite;
        ex_wdata    <= writeData;
        ex_target   <= branchTarget;
        ex_regwrite <= regWrite;
        ex_memread  <= memRead;
        ex_memwrite <= memWrite;
        ex_memtoreg <= memToReg;
        ex_branch   <= branch;
        ex_uns      <= memUnsigned;
        ex_size     <= memSize;
      end

      unique case (state)
        S_IDLE: begin
          if (mem_op && !misaligned && (WAIT_STATES != 0)) begin
            state <= S_WAIT;
            cnt   <= '0;
          end
        end
        S_WAIT: begin
          if (cnt == LAST_CNT) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
      endcase

      if (memStall) begin
        writeBackEnable     <= 1'b0;
        misalignedException <= 1'b0;
      end else begin
        writeBackData       <= ex_memtoreg ? load_data : ex_alu;
        writeBackAddress    <= ex_rd;
        writeBackEnable     <= ex_regwrite & ~misaligned;
        misalignedException <= misaligned;
      end
    end
  end

  // Data memory is intentionally not reset; only the addressed lanes are written.
  always_ff @(posedge clk) begin
    if (do_store) begin
      unique case (ex_size)
        2'b00:   mem[idx][{ex_alu[1:0], 3'b000} +: 8]  <= ex_wdata[7:0];
        2'b01:   mem[idx][{ex_alu[1], 4'b0000} +: 16] <= ex_wdata[15:0];
        default: mem[idx] <= ex_wdata;
      endcase
    end
  end
endmodule

// File: tb/tb_memoryaccessing.sv
// Self-checking bench for memoryaccessing: directed test-plan steps plus random
// loads/stores/ALU ops against a byte-addressed reference model (WAIT_STATES 2 and 0).
module tb_memoryaccessing;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu, wd, tgt;
  logic        zero, rw, mr, mw, m2r, br, uns;
  logic [4:0]  rd;
  logic [1:0]  sz;

  logic        stall2, pcsrc2, wbe2, exc2;
  logic [31:0] pcb2, wbd2;
  logic [4:0]  wba2;
  logic        stall0, pcsrc0, wbe0, exc0;
  logic [31:0] pcb0, wbd0;
  logic [4:0]  wba0;

  logic        sel;
  int          ws;
  logic        o_stall, o_pcsrc, o_wbe, o_exc;
  logic [31:0] o_pcb, o_wbd;
  logic [4:0]  o_wba;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] mdl [64];

  always #5 clk = ~clk;

  memoryaccessing #(.DEPTH(256), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset), .resultAluOutput(alu), .isAluOutputZero(zero),
    .addressRegWrite(rd), .writeData(wd), .branchTarget(tgt), .regWrite(rw),
    .memRead(mr), .memWrite(mw), .memToReg(m2r), .branch(br), .memUnsigned(uns),
    .memSize(sz), .memStall(stall2), .pcSrc(pcsrc2), .pcBranch(pcb2),
    .writeBackData(wbd2), .writeBackAddress(wba2), .writeBackEnable(wbe2),
    .misalignedException(exc2));

  memoryaccessing #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .resultAluOutput(alu), .isAluOutputZero(zero),
    .addressRegWrite(rd), .writeData(wd), .branchTarget(tgt), .regWrite(rw),
    .memRead(mr), .memWrite(mw), .memToReg(m2r), .branch(br), .memUnsigned(uns),
    .memSize(sz), .memStall(stall0), .pcSrc(pcsrc0), .pcBranch(pcb0),
    .writeBackData(wbd0), .writeBackAddress(wba0), .writeBackEnable(wbe0),
    .misalignedException(exc0));

  assign o_stall = sel ? stall0 : stall2;
  assign o_pcsrc = sel ? pcsrc0 : pcsrc2;
  assign o_pcb   = sel ? pcb0   : pcb2;
  assign o_wbd   = sel ? wbd0   : wbd2;
  assign o_wba   = sel ? wba0   : wba2;
  assign o_wbe   = sel ? wbe0   : wbe2;
  assign o_exc   = sel ? exc0   : exc2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nop();
    alu = '0; zero = 0; rd = '0; wd = '0; tgt = '0;
    rw = 0; mr = 0; mw = 0; m2r = 0; br = 0; uns = 0; sz = 2'b00;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, {31'b0, o_stall}, 32'd0);
    chk({tag, "_pcsrc"}, {31'b0, o_pcsrc}, 32'd0);
    chk({tag, "_pcbranch"}, o_pcb, 32'd0);
    chk({tag, "_wbdata"}, o_wbd, 32'd0);
    chk({tag, "_wbaddr"}, {27'b0, o_wba}, 32'd0);
    chk({tag, "_wben"}, {31'b0, o_wbe}, 32'd0);
    chk({tag, "_exc"}, {31'b0, o_exc}, 32'd0);
  endtask

  // Issues one instruction, waits out its stall and checks the MEM/WB result.
  task automatic run_op(input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                        input logic c_rw, input logic c_mr, input logic c_mw, input logic c_m2r,
                        input logic c_br, input logic c_z, input logic c_uns,
                        input logic [1:0] c_sz, input logic [31:0] t);
    logic        is_mem, mis;
    logic [5:0]  bw, bh, bb;
    logic [7:0]  bv;
    logic [15:0] hv;
    logic [31:0] ld, exp_data;
    int          stalls;
    is_mem = c_mr | c_mw;
    mis = is_mem && ((c_sz == 2'b01 && a[0]) || (c_sz[1] && a[1:0] != 2'b00));
    bw = {a[5:2], 2'b00};
    bh = {a[5:1], 1'b0};
    bb = a[5:0];
    bv = mdl[bb];
    hv = {mdl[bh + 6'd1], mdl[bh]};
    if (c_sz == 2'b00)      ld = c_uns ? {24'b0, bv} : {{24{bv[7]}}, bv};
    else if (c_sz == 2'b01) ld = c_uns ? {16'b0, hv} : {{16{hv[15]}}, hv};
    else ld = {mdl[bw + 6'd3], mdl[bw + 6'd2], mdl[bw + 6'd1], mdl[bw]};
    exp_data = c_m2r ? ld : a;

    @(negedge clk);
    alu = a; wd = d; rd = r; rw = c_rw; mr = c_mr; mw = c_mw; m2r = c_m2r;
    br = c_br; zero = c_z; uns = c_uns; sz = c_sz; tgt = t;
    @(posedge clk);
    #1 nop();
    @(negedge clk);
    chk("pc_src", {31'b0, o_pcsrc}, {31'b0, c_br & c_z});
    chk("pc_branch", o_pcb, t);
    stalls = 0;
    while (o_stall === 1'b1 && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    chk("stall_cycles", 32'(stalls), (is_mem && !mis) ? 32'(ws) : 32'd0);
    @(posedge clk);
    #1;
    chk("wb_addr", {27'b0, o_wba}, {27'b0, r});
    chk("wb_en", {31'b0, o_wbe}, {31'b0, c_rw & ~mis});
    chk("misaligned", {31'b0, o_exc}, {31'b0, mis});
    if (!mis) chk("wb_data", o_wbd, exp_data);

    if (c_mw && !c_mr && !mis) begin
      if (c_sz == 2'b00) mdl[bb] = d[7:0];
      else if (c_sz == 2'b01) begin
        mdl[bh] = d[7:0]; mdl[bh + 6'd1] = d[15:8];
      end else begin
        mdl[bw] = d[7:0]; mdl[bw + 6'd1] = d[15:8];
        mdl[bw + 6'd2] = d[23:16]; mdl[bw + 6'd3] = d[31:24];
      end
    end
  endtask

  task automatic init_region();
    logic [31:0] r;
    for (int i = 0; i < 16; i++) begin
      r = $urandom();
      run_op({r[31:10], 4'b0000, 4'(i), 2'b00}, $urandom(), 5'd0,
             0, 0, 1, 0, 0, 0, 0, 2'b10, 32'd0);
    end
  endtask

  task automatic random_ops(input int n);
    logic [31:0] r;
    int          kind;
    for (int i = 0; i < n; i++) begin
      r = $urandom();
      kind = $urandom_range(0, 3);
      run_op({r[31:10], 4'b0000, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))},
             $urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             kind == 1 || kind == 3, kind == 2 || kind == 3, kind == 1 || kind == 3,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), $urandom());
    end
  endtask

  initial begin
    sel = 0;
    ws = 2;
    nop();
    reset = 0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1;

    run_op(32'h10, 32'hDEADBEEF, 5'd0, 0, 0, 1, 0, 0, 0, 0, 2'b10, 32'd0);
    run_op(32'h10, 32'd0, 5'd8, 1, 1, 0, 1, 0, 0, 0, 2'b10, 32'd0);
    chk("load_word", o_wbd, 32'hDEADBEEF);
    run_op(32'h13, 32'h00000080, 5'd0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 32'd0);
    run_op(32'h13, 32'd0, 5'd9, 1, 1, 0, 1, 0, 0, 0, 2'b00, 32'd0);
    chk("load_byte_signed", o_wbd, 32'hFFFFFF80);
    run_op(32'h13, 32'd0, 5'd9, 1, 1, 0, 1, 0, 0, 1, 2'b00, 32'd0);
    chk("load_byte_unsigned", o_wbd, 32'h00000080);
    run_op(32'h10, 32'd0, 5'd10, 1, 1, 0, 1, 0, 0, 0, 2'b10, 32'd0);
    chk("other_lanes", o_wbd, 32'h80ADBEEF);

    run_op(32'h20, 32'hCAFEF00D, 5'd0, 0, 0, 1, 0, 0, 0, 0, 2'b10, 32'd0);
    run_op(32'h11, 32'd0, 5'd11, 1, 1, 0, 1, 0, 0, 0, 2'b01, 32'd0);
    @(posedge clk);
    #1 chk("exc_one_cycle", {31'b0, o_exc}, 32'd0);
    run_op(32'h22, 32'h12345678, 5'd0, 0, 0, 1, 0, 0, 0, 0, 2'b10, 32'd0);
    run_op(32'h20, 32'd0, 5'd12, 1, 1, 0, 1, 0, 0, 0, 2'b10, 32'd0);
    chk("misaligned_no_write", o_wbd, 32'hCAFEF00D);

    run_op(32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 32'h400);
    @(negedge clk);
    chk("branch_one_cycle", {31'b0, o_pcsrc}, 32'd0);
    run_op(32'd7, 32'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 32'h400);

    // Reset while the store sits in its WAIT cycle: the store must be dropped.
    @(negedge clk);
    alu = 32'h10; wd = 32'h11111111; mw = 1; sz = 2'b10;
    @(posedge clk);
    #1 nop();
    @(posedge clk);
    #1 reset = 0;
    #1 check_all_zero("reset_mid");
    @(negedge clk);
    reset = 1;
    run_op(32'h10, 32'd0, 5'd13, 1, 1, 0, 1, 0, 0, 0, 2'b10, 32'd0);
    chk("aborted_store", o_wbd, 32'h80ADBEEF);
    run_op(32'h1234, 32'd0, 5'd5, 1, 0, 0, 0, 0, 0, 0, 2'b00, 32'd0);
    chk("alu_data", o_wbd, 32'h1234);
    chk("alu_addr", {27'b0, o_wba}, 32'd5);

    init_region();
    random_ops(40);

    sel = 1;
    ws = 0;
    repeat (12) @(posedge clk);
    init_region();
    random_ops(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
